// File: rtl/seq_multiplier_pkg.sv
// Shared ALU package: FSM state encodings, default datapath width and a
// compile-time ceil(log2) helper used to size counters.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        SM_IDLE = 2'd0,
        SM_RUN  = 2'd1,
        SM_DONE = 2'd2
    } sm_state_e;

    // Bits needed to represent values 0 .. value-1; call with N+1 to hold N.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle for seq_multiplier. is_signed exists only when
// SEQ_MULT_SIGNED_EN is defined.
interface seq_multiplier_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef SEQ_MULT_SIGNED_EN
    logic             is_signed;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_lo;
    logic [WIDTH-1:0] product_hi;

    modport master (
`ifdef SEQ_MULT_SIGNED_EN
        output is_signed,
`endif
        output start, A, B,
        input  busy, done, product_lo, product_hi
    );

    modport slave (
`ifdef SEQ_MULT_SIGNED_EN
        input  is_signed,
`endif
        input  start, A, B,
        output busy, done, product_lo, product_hi
    );

endinterface

// File: rtl/seq_multiplier_addsub.sv
// Combinational W+1-bit conditional adder: sum_o = acc_i + (en_i ? addend_i : 0) + cin_i.
// Also serves as a negator when fed acc_i=0, addend_i=~x, en_i=1, cin_i=1.
module seq_mult_addsub
    import alu_pkg::*;
#(
    parameter int W = ALU_WIDTH
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] addend_i,
    input  logic         en_i,
    input  logic         cin_i,
    output logic [W:0]   sum_o
);

    logic [W-1:0] gated;

    always_comb begin
        gated = en_i ? addend_i : '0;
        sum_o = {1'b0, acc_i} + {1'b0, gated} + {{W{1'b0}}, cin_i};
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, WIDTH cycles per 2*WIDTH-bit product.
// Optional two's-complement mode: define SEQ_MULT_SIGNED_EN.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input logic            clk,
    input logic            rst_n,
    seq_multiplier_if.slave bus
);

    localparam int             CW       = clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(1);

    sm_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] step_prod;
    logic [2*WIDTH-1:0] final_prod;
    logic [WIDTH-1:0]   op_a, op_b;

    seq_mult_addsub #(.W(WIDTH)) u_step (
        .acc_i    (acc_q),
        .addend_i (mcand_q),
        .en_i     (mplier_q[0]),
        .cin_i    (1'b0),
        .sum_o    (step_sum)
    );

    // {carry, acc, multiplier} shifted right by one after the conditional add
    assign step_prod = {step_sum, mplier_q[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
    logic               sign_q, sign_d;
    logic               sign_start;
    logic [2*WIDTH:0]   neg_sum;
    logic               unused_neg_carry;
    logic [2*WIDTH-1:0] neg_prod;

    seq_mult_addsub #(.W(2*WIDTH)) u_neg (
        .acc_i    ('0),
        .addend_i (~step_prod),
        .en_i     (1'b1),
        .cin_i    (1'b1),
        .sum_o    (neg_sum)
    );

    assign {unused_neg_carry, neg_prod} = neg_sum;
    assign final_prod = sign_q ? neg_prod : step_prod;

    // Magnitude of a most-negative operand is itself when read as unsigned
    assign op_a       = (bus.is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign op_b       = (bus.is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    assign sign_start = bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
`else
    assign final_prod = step_prod;
    assign op_a       = bus.A;
    assign op_b       = bus.B;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d   = sign_q;
`endif
        case (state_q)
            SM_IDLE, SM_DONE: begin
                if (bus.start) begin
                    state_d  = SM_RUN;
                    cnt_d    = CNT_LOAD;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    prod_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
                    sign_d   = sign_start;
`endif
                end else begin
                    state_d = SM_IDLE;
                end
            end
            SM_RUN: begin
                acc_d    = step_prod[2*WIDTH-1:WIDTH];
                mplier_d = step_prod[WIDTH-1:0];
                cnt_d    = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    state_d = SM_DONE;
                    prod_d  = final_prod;
                end
            end
            default: state_d = SM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SM_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q   <= sign_d;
`endif
        end
    end

    assign bus.busy       = (state_q == SM_RUN);
    assign bus.done       = (state_q == SM_DONE);
    assign bus.product_lo = prod_q[WIDTH-1:0];
    assign bus.product_hi = prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed plus random bench for seq_multiplier against an arithmetic
// reference product; signed cases run when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (rst_n && (bus.busy || bus.done))
            chk("busy_done_exclusive", {63'b0, bus.busy & bus.done}, 64'd0);
    end

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.A = a;
        bus.B = b;
`ifdef SEQ_MULT_SIGNED_EN
        bus.is_signed = s;
`else
        if (s) $display("note: signed request ignored in unsigned build");
`endif
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        set_ops(a, b, s);
        bus.start = 1'b1;
    endtask

    // Called right after start was raised; counts edges until done is seen.
    task automatic collect(input string tag, input logic [63:0] exp, input int inj_cycle,
                           input bit chain, input logic [31:0] na, input logic [31:0] nb,
                           input logic ns);
        int cycles;
        int busy_n;
        cycles = 0;
        busy_n = 0;
        while (cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) bus.start = 1'b0;
            if (inj_cycle != 0 && cycles == inj_cycle) begin
                bus.start = 1'b1;
                bus.A     = 32'd100;
                bus.B     = 32'd100;
            end else if (inj_cycle != 0 && cycles == inj_cycle + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
            if (bus.busy) busy_n++;
        end
        chk({tag, "_latency"}, cycles, 64'd33);
        chk({tag, "_busy_cycles"}, busy_n, 64'd32);
        chk({tag, "_product"}, {bus.product_hi, bus.product_lo}, exp);
        if (chain) begin
            set_ops(na, nb, ns);
            bus.start = 1'b1;
        end else begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, {63'b0, bus.done}, 64'd0);
            chk({tag, "_held"}, {bus.product_hi, bus.product_lo}, exp);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          d0;

        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_ops(32'd0, 32'd0, 1'b0);
        #1;
        chk("reset_busy", {63'b0, bus.busy}, 64'd0);
        chk("reset_done", {63'b0, bus.done}, 64'd0);
        chk("reset_product", {bus.product_hi, bus.product_lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        launch(32'd3, 32'd5, 1'b0);
        collect("basic", 64'h0000_0000_0000_000F, 0, 1'b0, '0, '0, 1'b0);

        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        collect("max", 64'hFFFF_FFFE_0000_0001, 0, 1'b0, '0, '0, 1'b0);

        d0 = done_cnt;
        launch(32'd7, 32'd6, 1'b0);
        collect("busy_reject", 64'd42, 10, 1'b0, '0, '0, 1'b0);
        repeat (40) @(negedge clk);
        chk("busy_reject_one_done", done_cnt - d0, 64'd1);

        launch(32'd2, 32'd9, 1'b0);
        collect("b2b_first", 64'h12, 0, 1'b1, 32'd4, 32'd4, 1'b0);
        collect("b2b_second", 64'h10, 0, 1'b0, '0, '0, 1'b0);

        launch(32'h1234, 32'h1234, 1'b0);
        repeat (15) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'b0, bus.busy}, 64'd0);
        chk("abort_done", {63'b0, bus.done}, 64'd0);
        chk("abort_product", {bus.product_hi, bus.product_lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 64'd0);
        launch(32'h1234, 32'h1234, 1'b0);
        collect("after_abort", 64'h0000_0000_014B_5A90, 0, 1'b0, '0, '0, 1'b0);

`ifdef SEQ_MULT_SIGNED_EN
        launch(32'hFFFF_FFFD, 32'd5, 1'b1);
        collect("signed_neg3x5", 64'hFFFF_FFFF_FFFF_FFF1, 0, 1'b0, '0, '0, 1'b0);
        launch(32'h8000_0000, 32'h8000_0000, 1'b1);
        collect("signed_minmin", 64'h4000_0000_0000_0000, 0, 1'b0, '0, '0, 1'b0);
`endif

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
`ifdef SEQ_MULT_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            launch(ra, rb, rs);
            collect("random", model(ra, rb, rs), 0, 1'b0, '0, '0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-add multiplier for the ALU datapath. It takes two WIDTH-bit operands on a start strobe and produces a 2·WIDTH-bit product over WIDTH cycles. A one-cycle done pulse marks the result. The block sits directly upstream of the ALU's 2:1 result mux: product_lo feeds the mux's B input, and the ALU selects it with S=1 when a multiply is issued.

## Interface
- WIDTH, 32, operand width in bits; the product is 2·WIDTH bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  multiplicand, captured on an accepted start.
- B  input  WIDTH  multiplier, captured on an accepted start.
- is_signed  input  1  two's-complement mode; present only with SEQ_MULT_SIGNED_EN.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- product_lo  output  WIDTH  low half of the product.
- product_hi  output  WIDTH  high half of the product.

## Operation
- Reset state: IDLE. busy=0, done=0, product_lo=0, product_hi=0, counter=0, internal operand registers=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start=1. The block captures A and B, clears the accumulator and loads counter=WIDTH.
  - RUN: each cycle, if multiplier bit0=1, add the multiplicand to the upper half of the accumulator using a WIDTH+1-bit sum (carry kept). Then shift the {carry, accumulator, multiplier} combination right by 1 and decrement counter. When counter reaches 1, move to DONE on that edge.
  - DONE: done=1 for exactly one cycle, with the product registered. Next state is RUN if start=1, otherwise IDLE.
- start in RUN is ignored. It is not queued, and the captured operands do not change.
- The product is held on product_hi/product_lo until the next accepted start clears it.
- Arithmetic is unsigned by default, with no overflow: the full 2·WIDTH product is always exact.
- Reset asserted mid-RUN aborts immediately. All outputs return to their reset values, and no done pulse is issued.

## Timing
- Call the edge that samples start=1 in IDLE "edge 0".
- busy is high after edge 0 through edge WIDTH.
- done is high in the cycle following edge WIDTH, so the result is valid WIDTH+1 edges after the start sample. With WIDTH=32 this is 33 cycles start-to-done.
- busy and done are never high in the same cycle.
- Back-to-back: start=1 during the DONE cycle is accepted. RUN begins on the next edge, so throughput is one operation per WIDTH+1 cycles.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - The is_signed port exists.
  - When is_signed=1 at start, the block stores the magnitudes of A and B and records sign = A[MSB] XOR B[MSB].
  - On entry to DONE it writes the two's-complement negation of the 2·WIDTH product if sign=1.
  - Latency is unchanged. Negating a most-negative operand still gives the correct 2·WIDTH result.
- Not defined:
  - No is_signed port.
  - Operation is unsigned only.
  - No sign or negate logic is synthesised.

## Structure
- The shared package alu_pkg holds:
  - state encodings SM_IDLE=2'd0, SM_RUN=2'd1, SM_DONE=2'd2;
  - the default-width constant ALU_WIDTH=32;
  - the counter-width function clog2(WIDTH+1).
- One sub-module, seq_mult_addsub. It is a combinational WIDTH+1-bit conditional adder (addend gated by the multiplier LSB) that returns {carry, sum*}. In signed builds the same module is reused as the final negator via invert plus carry-in.
- The FSM, counter and shift registers live in the top module.

## Test plan
- Basic unsigned: A=3, B=5, one start pulse → done exactly 33 cycles later; product_hi=0x00000000, product_lo=0x0000000F; busy high for 32 cycles.
- Max operands: A=B=0xFFFFFFFF → product_hi=0xFFFFFFFE, product_lo=0x00000001.
- Busy rejection: start A=7,B=6, then at cycle 10 pulse start with A=100,B=100 → result still 0x2A, done still at cycle 33, exactly one done pulse.
- Back-to-back: hold start=1 with A=2,B=9, and with A=4,B=4 during the DONE cycle → first result 0x12, second done 33 cycles after the first with product_lo=0x10.
- Reset mid-operation: A=B=0x1234, deassert rst_n at cycle 15 for 2 cycles → busy=0, done=0, product=0; no done pulse follows; the next start gives 0x014B5A90.
- Signed (SEQ_MULT_SIGNED_EN): is_signed=1, A=0xFFFFFFFD (−3), B=5 → product_hi=0xFFFFFFFF, product_lo=0xFFFFFFF1. Also A=B=0x80000000 → product_hi=0x40000000, product_lo=0.
